// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x oversampling, majority vote, parity/stop checks, ready/ack handshake.
// Optional break detection is enabled with the UART_RX_BREAK_DETECT_EN macro.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick_16x,
  input  logic                 rx_serial,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 rx_error,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_break
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t               state;
  logic                 sync1, sync2, baud_q;
  logic [3:0]           cnt;
  logic [3:0]           bit_idx;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 stop_bad;

  logic       tick, vote, done, frame_err, par_err, is_break;
  logic [3:0] cnt_inc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      baud_q <= 1'b1;
    end else begin
      sync1  <= rx_serial;
      sync2  <= sync1;
      baud_q <= baud_tick_16x;
    end
  end

  assign tick    = baud_tick_16x & ~baud_q;
  assign cnt_inc = cnt + 4'd1;
  // Majority of the samples at counters 7 and 8 plus the live sample at counter 9.
  assign vote    = (samp[0] & samp[1]) | (samp[0] & sync2) | (samp[1] & sync2);
  assign done    = tick && (state == STOP) && (cnt_inc == 4'd9) &&
                   (bit_idx == 4'(STOP_BITS - 1));
  assign frame_err = stop_bad | ~vote;
  assign par_err   = (PARITY_MODE != 0) &&
                     (par_bit != (^shift ^ (PARITY_MODE == 2)));

`ifdef UART_RX_BREAK_DETECT_EN
  logic all_zero;

  assign is_break = all_zero & ~vote;

  always_ff @(posedge clk) begin
    if (rst) begin
      all_zero <= 1'b1;
      rx_break <= 1'b0;
    end else begin
      if (rx_ack) rx_break <= 1'b0;
      if (tick) begin
        if (state == IDLE)
          all_zero <= 1'b1;
        else if ((cnt_inc == 4'd9) && (state inside {DATA, PARITY, STOP}))
          all_zero <= all_zero & ~vote;
        if (done && is_break) rx_break <= 1'b1;
      end
    end
  end
`else
  assign is_break = 1'b0;
  assign rx_break = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      bit_idx       <= 4'd0;
      samp          <= 2'b11;
      shift         <= '0;
      par_bit       <= 1'b0;
      stop_bad      <= 1'b0;
      rx_data       <= '0;
      rx_ready      <= 1'b0;
      rx_error      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (rx_ack && rx_ready) begin
        rx_ready   <= 1'b0;
        rx_overrun <= 1'b0;
      end

      if (tick) begin
        cnt <= cnt_inc;
        if (cnt_inc == 4'd7) samp[0] <= sync2;
        if (cnt_inc == 4'd8) samp[1] <= sync2;

        case (state)
          IDLE: begin
            cnt <= 4'd0;
            if (!sync2) begin
              state    <= START;
              bit_idx  <= 4'd0;
              stop_bad <= 1'b0;
            end
          end
          START: begin
            if ((cnt_inc == 4'd9) && vote) begin
              state <= IDLE;
              cnt   <= 4'd0;
            end else if (cnt_inc == 4'd15) begin
              state <= DATA;
            end
          end
          DATA: begin
            if (cnt_inc == 4'd9) shift <= {vote, shift[DATA_BITS-1:1]};
            if (cnt_inc == 4'd15) begin
              if (bit_idx == 4'(DATA_BITS - 1)) begin
                bit_idx <= 4'd0;
                state   <= (PARITY_MODE != 0) ? PARITY : STOP;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end
          end
          PARITY: begin
            if (cnt_inc == 4'd9)  par_bit <= vote;
            if (cnt_inc == 4'd15) state   <= STOP;
          end
          STOP: begin
            if (done) begin
              // Completion at the middle of the last stop bit; no wait for its end.
              state <= is_break ? BRK_WAIT : IDLE;
              cnt   <= 4'd0;
              if (!is_break) begin
                if (!rx_ready || rx_ack) begin
                  rx_data       <= shift;
                  rx_error      <= frame_err;
                  rx_parity_err <= par_err;
                  rx_ready      <= 1'b1;
                end else begin
                  rx_overrun <= 1'b1;
                end
              end
            end else begin
              if (cnt_inc == 4'd9)  stop_bad <= stop_bad | ~vote;
              if (cnt_inc == 4'd15) bit_idx  <= bit_idx + 4'd1;
            end
          end
          BRK_WAIT: begin
            cnt <= 4'd0;
            if (sync2) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E2 instance share clk, tick and reset.
// Vector table, hand-written corner sequences and random frames checked against a frame-level model.
module tb_uart_rx_param;

  logic       clk = 1'b0, rst = 1'b1, baud = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1, ack_a = 1'b0, ack_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       rdy_a, err_a, perr_a, ovr_a, brk_a;
  logic       rdy_b, err_b, perr_b, ovr_b, brk_b;
  bit         sel = 1'b0;

  logic [7:0] obs_data;
  logic       obs_ready, obs_err, obs_perr, obs_ovr, obs_brk;

  int         n_tests = 0, n_fail = 0;
  int         rise_at;
  logic [7:0] cap_data;
  logic       cap_err, cap_perr;

  uart_rx_param dut_a (
    .clk(clk), .rst(rst), .baud_tick_16x(baud), .rx_serial(rx_a), .rx_ack(ack_a),
    .rx_data(data_a), .rx_ready(rdy_a), .rx_error(err_a), .rx_parity_err(perr_a),
    .rx_overrun(ovr_a), .rx_break(brk_a)
  );

  uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .baud_tick_16x(baud), .rx_serial(rx_b), .rx_ack(ack_b),
    .rx_data(data_b), .rx_ready(rdy_b), .rx_error(err_b), .rx_parity_err(perr_b),
    .rx_overrun(ovr_b), .rx_break(brk_b)
  );

  assign obs_data  = sel ? data_b : data_a;
  assign obs_ready = sel ? rdy_b  : rdy_a;
  assign obs_err   = sel ? err_b  : err_a;
  assign obs_perr  = sel ? perr_b : perr_a;
  assign obs_ovr   = sel ? ovr_b  : ovr_a;
  assign obs_brk   = sel ? brk_b  : brk_a;

  always #5 clk = ~clk;

  // 65 ns tick period, offset so its rising edge never coincides with a clk edge.
  initial begin
    #3;
    forever begin
      baud = 1'b1;
      #20;
      baud = 1'b0;
      #45;
    end
  end

  typedef struct {
    bit         sel;
    logic [7:0] data;
    bit         flip;
    logic [1:0] bad;
    logic [7:0] exp_data;
    bit         exp_err;
    bit         exp_perr;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_line(input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic set_ack(input logic v);
    if (sel) ack_b = v;
    else     ack_a = v;
  endtask

  task automatic do_ack();
    @(negedge clk);
    set_ack(1'b1);
    @(negedge clk);
    set_ack(1'b0);
    @(negedge clk);
  endtask

  // Bit i of the result is the line level during bit time i; bit 0 is the start bit.
  function automatic logic [15:0] frame(input bit s, input logic [7:0] d, input bit flip,
                                        input logic [1:0] bad);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (s) begin
      f[9]  = (^d) ^ flip;
      f[10] = ~bad[0];
      f[11] = ~bad[1];
    end else begin
      f[9] = ~bad[0];
    end
    return f;
  endfunction

  // Drives len bit times then gap idle ticks; records the tick offset of the first rx_ready rise.
  task automatic send(input logic [15:0] bits, input int len, input int gap,
                      input int ack_tick, input int rst_tick);
    logic prev;
    rise_at = -1;
    prev    = obs_ready;
    for (int i = 0; i < len * 16 + gap; i++) begin
      @(posedge baud);
      if (i == ack_tick) begin
        set_ack(1'b1);
        @(posedge clk);
        #1 set_ack(1'b0);
      end else if (i == rst_tick) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        #1;
      end
      drive_line((i < len * 16) ? bits[i / 16] : 1'b1);
      repeat (2) @(negedge clk);
      if (!prev && obs_ready && rise_at < 0) begin
        rise_at  = i - 1;
        cap_data = obs_data;
        cap_err  = obs_err;
        cap_perr = obs_perr;
      end
      prev = obs_ready;
    end
  endtask

  initial begin
    logic [7:0]  d;
    logic [1:0]  bad;
    logic [15:0] f;
    bit          flip;
    bit          exp_err, exp_perr;
    int          glitch_rise, len, exp_lat;

    vecs[0] = '{0, 8'h41, 0, 2'b00, 8'h41, 0, 0, 153};
    vecs[1] = '{0, 8'h42, 0, 2'b00, 8'h42, 0, 0, 153};
    vecs[2] = '{1, 8'h42, 0, 2'b00, 8'h42, 0, 0, 185};
    vecs[3] = '{1, 8'h42, 1, 2'b00, 8'h42, 0, 1, 185};
    vecs[4] = '{0, 8'h55, 0, 2'b01, 8'h55, 1, 0, 153};
    vecs[5] = '{1, 8'hA7, 0, 2'b10, 8'hA7, 1, 0, 185};
    vecs[6] = '{1, 8'h3D, 1, 2'b01, 8'h3D, 1, 1, 185};

    repeat (3) @(negedge clk);
    check("reset_data",  {24'd0, data_a}, 32'h0);
    check("reset_flags", {27'd0, rdy_a, err_a, perr_a, ovr_a, brk_a}, 32'h0);
    check("reset_b",     {27'd0, rdy_b, err_b, perr_b, ovr_b, brk_b}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      sel = vecs[v].sel;
      send(frame(vecs[v].sel, vecs[v].data, vecs[v].flip, vecs[v].bad),
           vecs[v].sel ? 12 : 10, 8, -1, -1);
      check($sformatf("v%0d_latency", v), rise_at, vecs[v].exp_lat);
      check($sformatf("v%0d_data", v), {24'd0, cap_data}, {24'd0, vecs[v].exp_data});
      check($sformatf("v%0d_err", v), {31'd0, cap_err}, {31'd0, vecs[v].exp_err});
      check($sformatf("v%0d_perr", v), {31'd0, cap_perr}, {31'd0, vecs[v].exp_perr});
      do_ack();
      check($sformatf("v%0d_ack_clears", v), {31'd0, obs_ready}, 32'd0);
    end

    // 4-tick low glitch must be rejected as a false start.
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge baud);
      #1 rx_a = 1'b0;
    end
    @(posedge baud);
    #1 rx_a = 1'b1;
    glitch_rise = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge baud);
      repeat (2) @(negedge clk);
      if (rdy_a) glitch_rise++;
    end
    check("glitch_no_ready", glitch_rise, 0);
    send(frame(0, 8'h5A, 0, 2'b00), 10, 8, -1, -1);
    check("after_glitch_lat", rise_at, 153);
    check("after_glitch_data", {24'd0, cap_data}, 32'h5A);
    do_ack();

    // Overrun, ack clearing, then ack coincident with completion.
    send(frame(0, 8'h11, 0, 2'b00), 10, 8, -1, -1);
    check("ovr_first_ready", {31'd0, rdy_a}, 32'd1);
    send(frame(0, 8'h22, 0, 2'b00), 10, 8, -1, -1);
    check("ovr_data_kept", {24'd0, data_a}, 32'h11);
    check("ovr_flag", {31'd0, ovr_a}, 32'd1);
    check("ovr_ready_held", {31'd0, rdy_a}, 32'd1);
    do_ack();
    check("ovr_ack_ready", {31'd0, rdy_a}, 32'd0);
    check("ovr_ack_flag", {31'd0, ovr_a}, 32'd0);
    send(frame(0, 8'h33, 0, 2'b00), 10, 8, -1, -1);
    check("pre_sameack_data", {24'd0, data_a}, 32'h33);
    send(frame(0, 8'h44, 0, 2'b00), 10, 8, 154, -1);
    check("sameack_data", {24'd0, data_a}, 32'h44);
    check("sameack_ready", {31'd0, rdy_a}, 32'd1);
    check("sameack_no_ovr", {31'd0, ovr_a}, 32'd0);
    do_ack();

    // Line held low for 12 bit times.
    send(16'h0000, 12, 16, -1, -1);
`ifdef UART_RX_BREAK_DETECT_EN
    check("break_flag", {31'd0, brk_a}, 32'd1);
    check("break_no_ready", rise_at, 32'hFFFF_FFFF);
`else
    check("break_frame_lat", rise_at, 153);
    check("break_frame_data", {24'd0, cap_data}, 32'h0);
    check("break_frame_err", {31'd0, cap_err}, 32'd1);
    send(16'hFFFF, 0, 200, -1, -1);
    do_ack();
    check("break_cleanup_ready", {31'd0, rdy_a}, 32'd0);
`endif
    send(frame(0, 8'h3C, 0, 2'b00), 10, 8, -1, -1);
    check("post_break_data", {24'd0, cap_data}, 32'h3C);
    check("post_break_err", {30'd0, cap_err, cap_perr}, 32'd0);
    do_ack();
    check("post_break_brk_clear", {31'd0, brk_a}, 32'd0);

    // Random frames against the frame-level model.
    for (int n = 0; n < 16; n++) begin
      sel  = bit'($urandom_range(0, 1));
      d    = 8'($urandom);
      flip = bit'($urandom_range(0, 1));
      bad  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (!sel) bad[1] = 1'b0;
      if (d == 8'h00) bad = 2'b00;
      f        = frame(sel, d, flip, bad);
      len      = sel ? 12 : 10;
      exp_err  = (bad != 2'b00);
      exp_perr = sel && ((($countones(d) + int'(f[9])) % 2) != 0);
      exp_lat  = (1 + 8 + (sel ? 1 : 0) + (sel ? 2 : 1) - 1) * 16 + 9;
      send(f, len, 4, -1, -1);
      check($sformatf("rnd%0d_lat", n), rise_at, exp_lat);
      check($sformatf("rnd%0d_data", n), {24'd0, cap_data}, {24'd0, d});
      check($sformatf("rnd%0d_err", n), {31'd0, cap_err}, {31'd0, exp_err});
      check($sformatf("rnd%0d_perr", n), {31'd0, cap_perr}, {31'd0, exp_perr});
      do_ack();
    end

    // Reset mid-frame while a previous word is still held.
    sel = 1'b0;
    send(frame(0, 8'h12, 1'b0, 2'b01), 10, 8, -1, -1);
    check("pre_rst_ready", {31'd0, rdy_a}, 32'd1);
    send(frame(0, 8'hFF, 0, 2'b00), 10, 8, -1, 40);
    check("rst_no_ready", rise_at, 32'hFFFF_FFFF);
    check("rst_data", {24'd0, data_a}, 32'h0);
    check("rst_flags", {27'd0, rdy_a, err_a, perr_a, ovr_a, brk_a}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
